// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive sequencing controller.
// Provides the frame state encoding, timing constants and the
// bit-index helpers used by the controller and its counter.
package uart_rx_ctrl_pkg;

  // Frame phases walked by the controller.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } rx_state_e;

  // Only oversampling ratio the controller supports.
  localparam logic [3:0] LEGAL_PRESCALE = 4'd8;

  // Last oversampling edge of a bit; sampled_bit is stable from here on.
  localparam logic [2:0] EDGE_LAST = 3'd7;

  // Bit index of the start bit within a frame.
  localparam logic [3:0] START_BIT = 4'd0;

  // Data bits follow the start bit, LSB first.
  function automatic logic [3:0] first_data_bit();
    return 4'd1;
  endfunction

  function automatic logic [3:0] last_data_bit(input int data_w);
    return 4'(data_w);
  endfunction

  // Parity (when present) sits right after the last data bit.
  function automatic logic [3:0] parity_bit(input int data_w);
    return 4'(data_w + 1);
  endfunction

  // Stop bit follows parity, or the last data bit when parity is off.
  function automatic logic [3:0] stop_bit(input int data_w, input logic par_en);
    return par_en ? 4'(data_w + 2) : 4'(data_w + 1);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_edge_bit_counter.sv
// Oversampling edge counter and frame bit counter for the UART RX controller.
// Ports: CLK/RST clock and async active-low reset; en_i advances the count,
//   clr_i zeroes both counters, load_i preloads edge=1/bit=0 for a
//   back-to-back start; edge_cnt_o/bit_cnt_o current position, edge_last_o
//   flags the final edge of a bit.
module uart_rx_ctrl_edge_bit_counter
  import uart_rx_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic       load_i,
  output logic [2:0] edge_cnt_o,
  output logic [3:0] bit_cnt_o,
  output logic       edge_last_o
);

  logic [2:0] edge_cnt_q, edge_cnt_d;
  logic [3:0] bit_cnt_q,  bit_cnt_d;

  // Priority: clear beats preload beats count. A back-to-back frame is
  // preloaded at edge 1 because the DONE cycle already served as edge 0
  // of the new start bit.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (clr_i) begin
      edge_cnt_d = 3'd0;
      bit_cnt_d  = START_BIT;
    end else if (load_i) begin
      edge_cnt_d = 3'd1;
      bit_cnt_d  = START_BIT;
    end else if (en_i) begin
      if (edge_cnt_q == EDGE_LAST) begin
        edge_cnt_d = 3'd0;
        bit_cnt_d  = bit_cnt_q + 4'd1;
      end else begin
        edge_cnt_d = edge_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q <= 3'd0;
      bit_cnt_q  <= START_BIT;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt_o  = edge_cnt_q;
  assign bit_cnt_o   = bit_cnt_q;
  assign edge_last_o = (edge_cnt_q == EDGE_LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencing controller for the UART receive path: walks each frame through
// start, data, optional parity and stop, strobing the datapath blocks.
// Ports: CLK/RST (async active-low); RX_IN serial line; Prescale/PAR_EN
//   config; strt_glitch/par_err/stp_err checker results; edge_cnt/bit_cnt
//   position; data_sample_en, deser_en and *_chk_en strobes; data_valid,
//   frame_err, parity_err frame pulses; cfg_err illegal Prescale level.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [3:0] Prescale,
  input  logic       PAR_EN,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic [2:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       data_sample_en,
  output logic       deser_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       cfg_err
);

  localparam logic [3:0] LAST_DATA = last_data_bit(DATA_W);

  rx_state_e state_q, state_d;
  logic      par_en_q, par_en_d;
  logic      p_flag_q, p_flag_d;
  logic      f_flag_q, f_flag_d;

  logic      edge_last;
  logic      cnt_en, cnt_clr, cnt_load;

  // Live decode so software sees a bad ratio immediately, even mid-frame.
  assign cfg_err = (Prescale != LEGAL_PRESCALE);

  uart_rx_ctrl_edge_bit_counter u_cnt (
    .CLK         (CLK),
    .RST         (RST),
    .en_i        (cnt_en),
    .clr_i       (cnt_clr),
    .load_i      (cnt_load),
    .edge_cnt_o  (edge_cnt),
    .bit_cnt_o   (bit_cnt),
    .edge_last_o (edge_last)
  );

  // Next-state logic. Checker results are consulted only on the last edge
  // of the bit they belong to.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!RX_IN && !cfg_err) state_d = ST_START;
      end
      ST_START: begin
        if (edge_last) state_d = strt_glitch ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (edge_last && (bit_cnt == LAST_DATA))
          state_d = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (edge_last) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (edge_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        // A low line here is the next start bit already in progress.
        state_d = RX_IN ? ST_IDLE : ST_START;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter control: free-run outside IDLE, zero whenever we head to IDLE,
  // preload when chaining straight from DONE into the next start bit.
  always_comb begin
    cnt_en   = (state_q != ST_IDLE);
    cnt_clr  = (state_d == ST_IDLE);
    cnt_load = (state_q == ST_DONE) && (state_d == ST_START);
  end

  // Output decode from registered state and counters only.
  always_comb begin
    data_sample_en = 1'b0;
    deser_en       = 1'b0;
    strt_chk_en    = 1'b0;
    par_chk_en     = 1'b0;
    stp_chk_en     = 1'b0;
    data_valid     = 1'b0;
    frame_err      = 1'b0;
    parity_err     = 1'b0;
    case (state_q)
      ST_START: begin
        data_sample_en = 1'b1;
        strt_chk_en    = edge_last;
      end
      ST_DATA: begin
        data_sample_en = 1'b1;
        deser_en       = edge_last;
      end
      ST_PARITY: begin
        data_sample_en = 1'b1;
        par_chk_en     = edge_last;
      end
      ST_STOP: begin
        data_sample_en = 1'b1;
        stp_chk_en     = edge_last;
      end
      ST_DONE: begin
        data_valid = !p_flag_q && !f_flag_q;
        parity_err = p_flag_q;
        frame_err  = f_flag_q;
      end
      default: ;
    endcase
  end

  // Sticky error flags collect checker results across the frame and are
  // consumed in DONE. Parity enable is frozen for the whole frame.
  always_comb begin
    par_en_d = (state_q == ST_IDLE) ? PAR_EN : par_en_q;
    if (state_q == ST_DONE) begin
      p_flag_d = 1'b0;
      f_flag_d = 1'b0;
    end else begin
      p_flag_d = p_flag_q | (par_chk_en & par_err);
      f_flag_d = f_flag_q | (stp_chk_en & stp_err);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      par_en_q <= 1'b0;
      p_flag_q <= 1'b0;
      f_flag_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      par_en_q <= par_en_d;
      p_flag_q <= p_flag_d;
      f_flag_q <= f_flag_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: table of single-frame scenarios plus
// hand-written back-to-back, reset-mid-frame and bad-Prescale sequences.
// All timing is measured in CLK cycles from the first START cycle (t=0).
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [3:0] Prescale;
  logic       PAR_EN;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic [2:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       data_sample_en;
  logic       deser_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       cfg_err;

  int n_chk  = 0;
  int n_fail = 0;

  uart_rx_ctrl #(.DATA_W(8)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .RX_IN          (RX_IN),
    .Prescale       (Prescale),
    .PAR_EN         (PAR_EN),
    .strt_glitch    (strt_glitch),
    .par_err        (par_err),
    .stp_err        (stp_err),
    .edge_cnt       (edge_cnt),
    .bit_cnt        (bit_cnt),
    .data_sample_en (data_sample_en),
    .deser_en       (deser_en),
    .strt_chk_en    (strt_chk_en),
    .par_chk_en     (par_chk_en),
    .stp_chk_en     (stp_chk_en),
    .data_valid     (data_valid),
    .frame_err      (frame_err),
    .parity_err     (parity_err),
    .cfg_err        (cfg_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       par_en;
    logic [7:0] dat;
    logic       glitch;
    logic       perr;
    logic       serr;
    int         exp_deser;  // number of deser_en pulses
    int         exp_done;   // cycle of the frame pulse, -1 = none
    int         exp_off;    // first cycle with data_sample_en low
    logic       exp_dv;
    logic       exp_pe;
    logic       exp_fe;
    int         exp_par;    // par_chk_en pulses
    int         exp_stp;    // stp_chk_en pulses
  } scn_t;

  scn_t scn [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // Serial level of frame bit idx: start, 8 data LSB first, even parity, stop, idle.
  function automatic logic frame_bit(input logic [7:0] d, input logic pe, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && pe) return ^d;
    return 1'b1;
  endfunction

  function automatic logic any_pulse();
    return data_valid | frame_err | parity_err;
  endfunction

  function automatic logic any_strobe();
    return deser_en | strt_chk_en | par_chk_en | stp_chk_en;
  endfunction

  task automatic idle_cycles(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic run_scn(input scn_t s, input int k);
    int t_strt = -1, t_done = -1, t_off = -1;
    int n_deser = 0, deser_bad = 0, strobe_bad = 0, n_par = 0, n_stp = 0, extra = 0;
    logic dv = 1'b0, pe = 1'b0, fe = 1'b0;
    string tag;
    tag = $sformatf("scn%0d", k);
    @(negedge CLK);
    PAR_EN = s.par_en; strt_glitch = s.glitch; par_err = s.perr; stp_err = s.serr;
    RX_IN = 1'b0;
    @(posedge CLK); #1;
    for (int t = 0; t < 100; t++) begin
      if (t == 0) chk({tag, "_edge0"}, 32'(edge_cnt), 0);
      if (deser_en) begin
        n_deser++;
        if (t != 15 + 8 * (n_deser - 1)) deser_bad++;
      end
      if (strt_chk_en && t_strt < 0) t_strt = t;
      if (any_strobe() && edge_cnt != 3'd7) strobe_bad++;
      if (par_chk_en) n_par++;
      if (stp_chk_en) n_stp++;
      if (any_pulse()) begin
        if (t_done < 0) begin
          t_done = t; dv = data_valid; pe = parity_err; fe = frame_err;
        end else extra++;
      end
      if (!data_sample_en && t_off < 0) t_off = t;
      RX_IN = s.glitch ? 1'b1 : frame_bit(s.dat, s.par_en, (t + 1) / 8);
      @(posedge CLK); #1;
    end
    chk({tag, "_strt_t"}, t_strt, 7);
    chk({tag, "_deser_n"}, n_deser, s.exp_deser);
    chk({tag, "_deser_pos"}, deser_bad, 0);
    chk({tag, "_strobe_edge"}, strobe_bad, 0);
    chk({tag, "_par_n"}, n_par, s.exp_par);
    chk({tag, "_stp_n"}, n_stp, s.exp_stp);
    chk({tag, "_done_t"}, t_done, s.exp_done);
    chk({tag, "_off_t"}, t_off, s.exp_off);
    chk({tag, "_extra"}, extra, 0);
    if (s.exp_done >= 0) begin
      chk({tag, "_dv"}, 32'(dv), 32'(s.exp_dv));
      chk({tag, "_pe"}, 32'(pe), 32'(s.exp_pe));
      chk({tag, "_fe"}, 32'(fe), 32'(s.exp_fe));
    end
    par_err = 1'b0; stp_err = 1'b0; strt_glitch = 1'b0;
    idle_cycles(3);
  endtask

  task automatic run_b2b();
    int n_dv = 0, t_dv0 = -1, t_dv1 = -1, n_err = 0;
    logic rx;
    @(negedge CLK);
    PAR_EN = 1'b0; RX_IN = 1'b0;
    @(posedge CLK); #1;
    for (int t = 0; t < 180; t++) begin
      if (data_valid) begin
        if (n_dv == 0) t_dv0 = t; else if (n_dv == 1) t_dv1 = t;
        n_dv++;
      end
      if (frame_err | parity_err) n_err++;
      if (t == 81) begin
        chk("b2b_edge_81", 32'(edge_cnt), 1);
        chk("b2b_bit_81", 32'(bit_cnt), 0);
        chk("b2b_sample_81", 32'(data_sample_en), 1);
      end
      if (t + 1 < 80) rx = frame_bit(8'h3C, 1'b0, (t + 1) / 8);
      else            rx = frame_bit(8'hC3, 1'b0, (t + 1 - 80) / 8);
      RX_IN = rx;
      @(posedge CLK); #1;
    end
    chk("b2b_dv_n", n_dv, 2);
    chk("b2b_dv_t0", t_dv0, 80);
    chk("b2b_dv_t1", t_dv1, 160);
    chk("b2b_err_n", n_err, 0);
    idle_cycles(3);
  endtask

  task automatic run_reset_mid();
    int n_act = 0;
    @(negedge CLK);
    PAR_EN = 1'b0; RX_IN = 1'b0;
    @(posedge CLK); #1;
    for (int t = 0; t < 36; t++) begin
      RX_IN = frame_bit(8'h96, 1'b0, (t + 1) / 8);
      @(posedge CLK); #1;
    end
    chk("rst_bit_pre", 32'(bit_cnt), 4);
    chk("rst_sample_pre", 32'(data_sample_en), 1);
    #1 RST = 1'b0;
    #1;
    chk("rst_edge", 32'(edge_cnt), 0);
    chk("rst_bit", 32'(bit_cnt), 0);
    chk("rst_outs", 32'({data_sample_en, any_strobe(), any_pulse()}), 0);
    RX_IN = 1'b1;
    @(negedge CLK); RST = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge CLK);
      if (any_pulse() | data_sample_en | any_strobe()) n_act++;
    end
    chk("rst_quiet", n_act, 0);
  endtask

  task automatic run_cfg();
    int n_act = 0;
    @(negedge CLK);
    Prescale = 4'd4; RX_IN = 1'b0;
    #1 chk("cfg_err_set", 32'(cfg_err), 1);
    for (int t = 0; t < 20; t++) begin
      @(negedge CLK);
      if (data_sample_en | any_strobe() | any_pulse() | (edge_cnt != 3'd0)) n_act++;
    end
    chk("cfg_stay_idle", n_act, 0);
    RX_IN = 1'b1; Prescale = 4'd8;
    #1 chk("cfg_err_clr", 32'(cfg_err), 0);
    idle_cycles(2);
  endtask

  initial begin
    scn[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8, 80, 80, 1'b1, 1'b0, 1'b0, 0, 1};
    scn[1] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 0, -1,  8, 1'b0, 1'b0, 1'b0, 0, 0};
    scn[2] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8, 88, 88, 1'b0, 1'b1, 1'b0, 1, 1};
    scn[3] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8, 80, 80, 1'b0, 1'b0, 1'b1, 0, 1};
    scn[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8, 80, 80, 1'b1, 1'b0, 1'b0, 0, 1};
    scn[5] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8, 88, 88, 1'b1, 1'b0, 1'b0, 1, 1};
    scn[6] = '{1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 8, 88, 88, 1'b0, 1'b1, 1'b1, 1, 1};

    RST = 1'b0; RX_IN = 1'b1; Prescale = 4'd8; PAR_EN = 1'b0;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset_edge", 32'(edge_cnt), 0);
    chk("reset_bit", 32'(bit_cnt), 0);
    chk("reset_outs", 32'({data_sample_en, any_strobe(), any_pulse()}), 0);
    chk("reset_cfg", 32'(cfg_err), 0);
    RST = 1'b1;
    idle_cycles(3);

    for (int k = 0; k < 7; k++) run_scn(scn[k], k);
    run_b2b();
    run_reset_mid();
    run_cfg();
    run_scn(scn[0], 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Sequencing controller for the UART receive path. Tracks oversampling edges and bit positions, walks each frame through start, data, optional parity and stop phases, and drives the enables of the data sampler, deserializer and the start/parity/stop checkers. Sits between RX_IN and the RX datapath blocks and produces the frame-level data_valid and error pulses.

## Interface
- DATA_W, 8, data bits per frame (LSB first)
- CLK  in  1  oversampling clock (Prescale edges per bit)
- RST  in  1  asynchronous, active-low reset
- RX_IN  in  1  serial line, idle high
- Prescale  in  4  edges per bit; only 8 is legal
- PAR_EN  in  1  parity bit present in frame
- strt_glitch  in  1  start checker result, valid while strt_chk_en=1
- par_err  in  1  parity checker result, valid while par_chk_en=1
- stp_err  in  1  stop checker result, valid while stp_chk_en=1
- edge_cnt  out  3  edge index within current bit, 0..7
- bit_cnt  out  4  bit index within frame (0=start, 1..DATA_W data, then parity, then stop)
- data_sample_en  out  1  sampler enable
- deser_en  out  1  one-cycle shift strobe per data bit
- strt_chk_en / par_chk_en / stp_chk_en  out  1 each  one-cycle checker strobes
- data_valid  out  1  one-cycle pulse, frame good
- frame_err / parity_err  out  1 each  one-cycle pulse, frame bad
- cfg_err  out  1  level, Prescale != 8

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE: counters held at 0, all strobes 0. RX_IN==0 and cfg_err==0 -> START; first START cycle has edge_cnt=0.
- Counter runs in every non-IDLE state: edge_cnt increments each CLK, wraps 7->0; bit_cnt increments on each wrap.
- Strobe edge: all check/shift strobes fire at edge_cnt==7 (sampled_bit is valid from edge 7).
- data_sample_en=1 in START, DATA, PARITY, STOP.
- START, edge 7: strt_chk_en=1; strt_glitch=1 -> IDLE, counters cleared; else -> DATA.
- DATA, edge 7: deser_en=1; after bit DATA_W -> PARITY if PAR_EN else STOP.
- PARITY, edge 7: par_chk_en=1; par_err latched into sticky p_flag; -> STOP unconditionally.
- STOP, edge 7: stp_chk_en=1; stp_err latched into sticky f_flag; -> DONE.
- DONE (exactly one cycle, edge_cnt=0): data_valid = !p_flag & !f_flag; parity_err = p_flag; frame_err = f_flag; flags cleared. RX_IN==0 -> START with edge_cnt continuing at 1, bit_cnt=0 (back-to-back frame); else -> IDLE.
- PAR_EN and Prescale are sampled only in IDLE; changes mid-frame ignored until next IDLE.
- cfg_err = (Prescale != 8), combinational from live input; while set, IDLE is not left. A frame in progress completes normally.

## Timing
- Reset: state IDLE, edge_cnt=0, bit_cnt=0, flags 0, all outputs 0 (cfg_err follows Prescale).
- Reset mid-frame: immediate return to IDLE, no data_valid/err pulse.
- All outputs decoded from registered state and counters; no input-to-output path except cfg_err and flag capture.
- Latency, first START cycle to DONE: 80 CLK without parity, 88 with parity (DATA_W=8).
- deser_en pulses at START+15, +23, ... +71 (8 pulses).
- Glitch abort: return to IDLE 8 CLK after START entry.

## Structure
- Shared package: state enum, LEGAL_PRESCALE=8, EDGE_LAST=3'd7, bit index constants (START_BIT=0, first/last data, parity, stop as functions of DATA_W and PAR_EN).
- Sub-module edge_bit_counter: enable, edge_cnt wrap at 7, bit_cnt increment on wrap, synchronous clear, preload edge_cnt=1 for back-to-back entry.
- FSM and output decode in uart_rx_ctrl.

## Test plan
- Prescale=8, PAR_EN=0, frame 0xA5 with good stop -> 8 deser_en pulses at START+15+8k, data_valid one cycle at START+80, no error pulses.
- RX_IN low for 2 CLK then high -> strt_chk_en at START+7, strt_glitch=1, back to IDLE at START+8, no deser_en.
- PAR_EN=1, par_err forced 1 during par_chk_en -> DONE at START+88, parity_err=1, data_valid=0.
- PAR_EN=0, stp_err=1 during stp_chk_en -> frame_err=1 at START+80, data_valid=0; next frame clean -> data_valid=1 (flags cleared).
- Two back-to-back frames 0x3C, 0xC3 with RX_IN low in DONE -> second START entered with edge_cnt=1, two data_valid pulses 80 CLK apart.
- RST low in DATA bit 4 -> all outputs 0 same cycle, IDLE; Prescale=4 with RX_IN low -> cfg_err=1, remains IDLE, no strobes.
